serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request one add/subtract; sampled on rising clk.
REQ-005 sub  input  1  0 = add (a+b+cin); 1 = subtract (a-b); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 sum  output  WIDTH  result, registered.
REQ-012 cout  output  1  final carry-out, registered (for subtract, 1 = no borrow).

Function
REQ-013 The block SHALL contain exactly one 1-bit full adder and evaluate one bit position per clock, LSB first: s = x^y^c, c' = majority(x,y,c).
REQ-014 FSM states SHALL be IDLE, RUN and DONE, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-015 IDLE: start=1 at edge 0 SHALL latch a, b (inverted if sub=1) and the carry (cin if sub=0, 1 if sub=1) into internal registers, clear the counter and enter RUN.
REQ-016 RUN: edges 1..WIDTH SHALL process bits 0..WIDTH-1, one per edge, shifting the result bit into an internal shift register.
REQ-017 At edge WIDTH the block SHALL copy the full result to sum, the final carry to cout, set done=1 and enter DONE.
REQ-018 DONE: at edge WIDTH+1 the block SHALL clear done and return to IDLE; total latency from start sampled to done high is WIDTH edges.
REQ-019 busy SHALL be 1 from edge 0 until edge WIDTH and 0 in IDLE and DONE.
REQ-020 sum and cout SHALL NOT change during RUN; they hold the previous result until the next completion.
REQ-021 start in RUN or DONE SHALL be ignored without being queued; a, b, sub and cin may change freely after edge 0 without affecting the result.
REQ-022 Back-to-back operation: start held high continuously SHALL begin a new operation on the first IDLE edge, i.e. every WIDTH+2 edges.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, with the overflow bit on cout; no signed-overflow flag is provided.
REQ-024 Counter SHALL not wrap: it is cleared on start and compared against WIDTH-1 to leave RUN.

Reset
REQ-025 rst=1 SHALL immediately (no clock needed) force state IDLE, counter 0, busy=0, done=0, sum=0, cout=0 and internal registers 0.
REQ-026 Reset during RUN SHALL abort the operation: no done pulse and no sum update; the first start after rst falls is processed normally.
REQ-027 start coincident with the rising edge at which rst is still high SHALL be ignored.

Verification (WIDTH=8)
REQ-028 a=0x00, b=0x00, cin=0, sub=0 -> done 8 edges after start, sum=0x00, cout=0; busy high for exactly 8 cycles.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
REQ-030 sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; sub=1, a=0x07, b=0x05, cin=1 -> sum=0x02, cout=1 (cin ignored).
REQ-031 start pulsed again at edges 3 and 9 of an operation (a=0x10, b=0x20), with inputs changed -> single done at edge 8, sum=0x30; sum stays at the prior value during RUN.
REQ-032 rst asserted asynchronously mid-RUN (edge 4) -> busy, done, sum and cout go to 0 before the next edge; no done follows; the next start completes correctly.
REQ-033 start held high with a=0x01, b=0x01 -> done pulses every 10 edges, each with sum=0x02, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder, one bit per clock, LSB first.
// Results land on sum/cout with a single-cycle done pulse WIDTH edges after start.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_c;

    // The single full adder, always looking at the current LSBs and carry.
    always_comb begin
        fa_s = a_q[0] ^ b_q[0] ^ c_q;
        fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1, so cin is replaced by a forced carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_c;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation from IDLE and measures what the DUT does; no checking here.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic icin, output int lat, output int busy_cnt,
                         output logic stable, output logic [W-1:0] r_sum,
                         output logic r_cout, output logic done_after);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        int           e;
        prev_sum  = sum;
        prev_cout = cout;
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; busy_cnt = 0; stable = 1'b1; e = 0;
        while (e < 40 && lat < 0) begin
            if (done) begin
                lat = e;
            end else begin
                if (busy) busy_cnt++;
                if (sum !== prev_sum || cout !== prev_cout) stable = 1'b0;
                a = W'($urandom); b = W'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
                tick();
                e++;
            end
        end
        r_sum  = sum;
        r_cout = cout;
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b1;
        tick();
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b sum=%h cout=%b expected all zero",
                     busy, done, sum, cout);
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_during_reset busy=%b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5]  = '{8'h00, 8'hFF, 8'hAA, 8'h05, 8'h07};
        logic [W-1:0] vb[5]  = '{8'h00, 8'h01, 8'h55, 8'h07, 8'h05};
        logic         vc[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic         vs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es[5]  = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h02};
        logic         ec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int lat, bc;
        logic st, rc, da;
        logic [W-1:0] rs;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], vc[i], lat, bc, st, rs, rc, da);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d expected 8", i, lat);
            end
            checks++;
            if (bc !== 8) begin
                errors++;
                $display("FAIL dir%0d_busy_cycles got %0d expected 8", i, bc);
            end
            checks++;
            if (rs !== es[i] || rc !== ec[i]) begin
                errors++;
                $display("FAIL dir%0d_result sum=%h cout=%b expected sum=%h cout=%b",
                         i, rs, rc, es[i], ec[i]);
            end
            checks++;
            if (st !== 1'b1 || da !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_hold_pulse stable=%b done_after=%b expected 1/0", i, st, da);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, t;
        logic st, rc, da, rsub, rcin, ecout;
        logic [W-1:0] rs, ra, rb, esum;
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rsub = 1'($urandom); rcin = 1'($urandom);
            if (rsub) begin
                t     = int'(ra) - int'(rb) + 256;
                esum  = W'(t % 256);
                ecout = (ra >= rb);
            end else begin
                t     = int'(ra) + int'(rb) + int'(rcin);
                esum  = W'(t % 256);
                ecout = (t >= 256);
            end
            do_op(ra, rb, rsub, rcin, lat, bc, st, rs, rc, da);
            checks++;
            if (rs !== esum || rc !== ecout || lat !== 8 || st !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h sub=%b cin=%b got sum=%h cout=%b lat=%0d stable=%b expected sum=%h cout=%b lat=8 stable=1",
                         i, ra, rb, rsub, rcin, rs, rc, lat, st, esum, ecout);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] prev_sum;
        int done_cnt, done_edge;
        logic moved, busy_late;
        prev_sum = sum;
        done_cnt = 0; done_edge = -1; moved = 1'b0; busy_late = 1'b0;
        for (int e = 0; e < 15; e++) begin
            start = (e == 0 || e == 3 || e == 9);
            if (e == 0) begin
                a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0;
            end else begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            end
            tick();
            if (done) begin
                done_cnt++;
                done_edge = e;
            end
            if (e < 8 && sum !== prev_sum) moved = 1'b1;
            if (e >= 9 && busy) busy_late = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (done_cnt !== 1 || done_edge !== 8) begin
            errors++;
            $display("FAIL ignore_start_done count=%0d edge=%0d expected 1 at 8", done_cnt, done_edge);
        end
        checks++;
        if (sum !== 8'h30) begin
            errors++;
            $display("FAIL ignore_start_sum got %h expected 30", sum);
        end
        checks++;
        if (moved !== 1'b0 || busy_late !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_side sum_moved=%b busy_after=%b expected 0/0", moved, busy_late);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        logic st, rc, da, seen;
        logic [W-1:0] rs;
        a = 8'h3C; b = 8'h0F; sub = 1'b0; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b sum=%h cout=%b expected all zero",
                     busy, done, sum, cout);
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done activity=%b expected 0", seen);
        end
        do_op(8'h3C, 8'h0F, 1'b0, 1'b1, lat, bc, st, rs, rc, da);
        checks++;
        if (rs !== 8'h4C || rc !== 1'b0 || lat !== 8) begin
            errors++;
            $display("FAIL after_reset_op sum=%h cout=%b lat=%0d expected 4c/0/8", rs, rc, lat);
        end
    endtask

    task automatic test_back_to_back();
        int   exp_edges[4] = '{8, 18, 28, 38};
        int   k;
        logic bad;
        a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        k = 0; bad = 1'b0;
        for (int e = 0; e < 46; e++) begin
            tick();
            if (done) begin
                if (k >= 4 || e != exp_edges[k] || sum !== 8'h02 || cout !== 1'b0) begin
                    bad = 1'b1;
                    $display("FAIL b2b_pulse edge=%0d sum=%h cout=%b expected edge=%0d sum=02 cout=0",
                             e, sum, cout, (k < 4) ? exp_edges[k] : -1);
                end
                k++;
            end
        end
        start = 1'b0;
        checks++;
        if (bad) errors++;
        checks++;
        if (k !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 4", k);
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_directed();
        test_random();
        tick();
        test_ignore_start();
        tick();
        test_reset_mid_run();
        tick();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
